// File: rtl/inflight_fetch_queue_if.sv
// Handshake and bus bundle for inflight_fetch_queue.
// slave  : queue side (receives enqueue/bus/cancel inputs, drives dequeue/status)
// master : fetch-pipeline side (mirror of slave)
interface inflight_fetch_queue_if #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PAYLOAD_W = 256,
  parameter int unsigned EXC_W     = 5,
  parameter int unsigned NCANCEL   = 3
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                 enq_valid_i;
  logic                 enq_ready_o;
  logic [PAYLOAD_W-1:0] enq_payload_i;
  logic                 enq_canceled_i;
  logic                 enq_has_exc_i;
  logic [EXC_W-1:0]     enq_exc_code_i;
  logic                 mmu_has_exc_i;
  logic [EXC_W-1:0]     mmu_exc_code_i;
  logic                 mmu_is_refill_i;
  logic [NCANCEL-1:0]   cancel_i;
  logic                 inst_data_ok_i;
  logic                 deq_valid_o;
  logic [PAYLOAD_W-1:0] deq_payload_o;
  logic                 deq_has_exc_o;
  logic [EXC_W-1:0]     deq_exc_code_o;
  logic                 deq_is_refill_o;
  logic [CNT_W-1:0]     count_o;
  logic                 empty_o;
  logic                 full_o;
  logic                 spurious_ok_o;

  modport slave (
    input  enq_valid_i, enq_payload_i, enq_canceled_i, enq_has_exc_i, enq_exc_code_i,
           mmu_has_exc_i, mmu_exc_code_i, mmu_is_refill_i, cancel_i, inst_data_ok_i,
    output enq_ready_o, deq_valid_o, deq_payload_o, deq_has_exc_o, deq_exc_code_o,
           deq_is_refill_o, count_o, empty_o, full_o, spurious_ok_o
  );

  modport master (
    output enq_valid_i, enq_payload_i, enq_canceled_i, enq_has_exc_i, enq_exc_code_i,
           mmu_has_exc_i, mmu_exc_code_i, mmu_is_refill_i, cancel_i, inst_data_ok_i,
    input  enq_ready_o, deq_valid_o, deq_payload_o, deq_has_exc_o, deq_exc_code_o,
           deq_is_refill_o, count_o, empty_o, full_o, spurious_ok_o
  );
endinterface

// File: rtl/inflight_fetch_queue.sv
// In-order tracker for outstanding instruction-fetch requests.
// Holds metadata for up to DEPTH requests; each inst_data_ok pops the oldest.
// Cancels mark every live entry so canceled requests drain without a valid bundle.
// Ports: clk, rst (sync, active-high), bus (inflight_fetch_queue_if.slave):
//   enq_* / mmu_* / cancel_i  request capture, inst_data_ok_i  pop strobe,
//   deq_*  head view, count_o/empty_o/full_o  occupancy, spurious_ok_o  data_ok while empty.
module inflight_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PAYLOAD_W = 256,
  parameter int unsigned EXC_W     = 5,
  parameter int unsigned NCANCEL   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  inflight_fetch_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 has_exc;
    logic [EXC_W-1:0]     exc_code;
    logic                 is_refill;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] canceled;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             spurious_q;

  logic   empty;
  logic   full;
  logic   push;
  logic   pop;
  logic   cancel_any;
  entry_t enq_entry;
  entry_t head;

  // Occupancy and handshake; a same-cycle pop frees a slot when full.
  always_comb begin
    empty       = (count == '0);
    full        = (count == CNT_W'(DEPTH));
    pop         = bus.inst_data_ok_i && !empty;
    bus.enq_ready_o = !full || pop;
    push        = bus.enq_valid_i && bus.enq_ready_o;
    cancel_any  = |bus.cancel_i;
  end

  // Exception merge: upstream exception wins, refill only meaningful for MMU faults.
  always_comb begin
    enq_entry.payload   = bus.enq_payload_i;
    enq_entry.has_exc   = bus.enq_has_exc_i | bus.mmu_has_exc_i;
    enq_entry.exc_code  = bus.enq_has_exc_i ? bus.enq_exc_code_i : bus.mmu_exc_code_i;
    enq_entry.is_refill = bus.mmu_is_refill_i && !bus.enq_has_exc_i;
  end

  // Metadata storage; no reset needed since pointers/count define liveness.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= enq_entry;
  end

  // Pointers, count, cancel bits and spurious pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      canceled   <= '0;
      spurious_q <= 1'b0;
    end else begin
      spurious_q <= bus.inst_data_ok_i && empty;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push && (wr_ptr == PTR_W'(i)))
          canceled[i] <= bus.enq_canceled_i | cancel_any;
        else if (cancel_any)
          canceled[i] <= 1'b1;
      end
    end
  end

  // Head view is combinational from storage, forced to zero when empty.
  always_comb begin
    head                = empty ? '0 : mem[rd_ptr];
    bus.deq_valid_o     = pop && !canceled[rd_ptr];
    bus.deq_payload_o   = head.payload;
    bus.deq_has_exc_o   = head.has_exc;
    bus.deq_exc_code_o  = head.exc_code;
    bus.deq_is_refill_o = head.is_refill;
    bus.count_o         = count;
    bus.empty_o         = empty;
    bus.full_o          = full;
    bus.spurious_ok_o   = spurious_q;
  end
endmodule

// File: tb/tb_inflight_fetch_queue.sv
// Directed self-checking bench for inflight_fetch_queue.
module tb_inflight_fetch_queue;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned PAYLOAD_W = 256;
  localparam int unsigned EXC_W     = 5;
  localparam int unsigned NCANCEL   = 3;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  inflight_fetch_queue_if #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .EXC_W(EXC_W), .NCANCEL(NCANCEL)) bus ();

  inflight_fetch_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .EXC_W(EXC_W), .NCANCEL(NCANCEL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle();
    bus.enq_valid_i     = 1'b0;
    bus.enq_payload_i   = '0;
    bus.enq_canceled_i  = 1'b0;
    bus.enq_has_exc_i   = 1'b0;
    bus.enq_exc_code_i  = '0;
    bus.mmu_has_exc_i   = 1'b0;
    bus.mmu_exc_code_i  = '0;
    bus.mmu_is_refill_i = 1'b0;
    bus.cancel_i        = '0;
    bus.inst_data_ok_i  = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [PAYLOAD_W-1:0] p);
    idle();
    bus.enq_valid_i   = 1'b1;
    bus.enq_payload_i = p;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++; if (bus.empty_o !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b want 1", bus.empty_o); end
    tests_run++; if (bus.full_o !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b want 0", bus.full_o); end
    tests_run++; if (bus.count_o !== CNT_W'(0)) begin tests_failed++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
    tests_run++; if (bus.deq_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_deq_valid got %b want 0", bus.deq_valid_o); end
    tests_run++; if (bus.spurious_ok_o !== 1'b0) begin tests_failed++; $display("FAIL reset_spurious got %b want 0", bus.spurious_ok_o); end
    tests_run++; if (bus.deq_payload_o !== '0 || bus.deq_has_exc_o !== 1'b0 || bus.deq_exc_code_o !== '0 || bus.deq_is_refill_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_deq_data got payload %h exc %b code %h refill %b want all 0",
                               bus.deq_payload_o[31:0], bus.deq_has_exc_o, bus.deq_exc_code_o, bus.deq_is_refill_o); end
    tests_run++; if (bus.enq_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_enq_ready got %b want 1", bus.enq_ready_o); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) push_one(PAYLOAD_W'(i));
    tests_run++; if (bus.full_o !== 1'b1) begin tests_failed++; $display("FAIL fill_full got %b want 1", bus.full_o); end
    tests_run++; if (bus.count_o !== CNT_W'(4)) begin tests_failed++; $display("FAIL fill_count got %0d want 4", bus.count_o); end
    tests_run++; if (bus.enq_ready_o !== 1'b0) begin tests_failed++; $display("FAIL fill_enq_ready got %b want 0", bus.enq_ready_o); end
    for (int i = 1; i <= 4; i++) begin
      bus.inst_data_ok_i = 1'b1;
      #1;
      tests_run++; if (bus.deq_valid_o !== 1'b1 || bus.deq_payload_o !== PAYLOAD_W'(i)) begin
        tests_failed++; $display("FAIL drain_%0d got valid %b payload %h want valid 1 payload %h", i, bus.deq_valid_o, bus.deq_payload_o[31:0], i); end
      tick();
      idle();
    end
    tests_run++; if (bus.empty_o !== 1'b1) begin tests_failed++; $display("FAIL drain_empty got %b want 1", bus.empty_o); end
  endtask

  task automatic test_back_to_back();
    int next_head;
    for (int i = 1; i <= 4; i++) push_one(PAYLOAD_W'(i));
    next_head = 1;
    for (int k = 0; k < 10; k++) begin
      bus.enq_valid_i    = 1'b1;
      bus.enq_payload_i  = PAYLOAD_W'(5 + k);
      bus.inst_data_ok_i = 1'b1;
      #1;
      tests_run++; if (bus.enq_ready_o !== 1'b1 || bus.deq_valid_o !== 1'b1 || bus.deq_payload_o !== PAYLOAD_W'(next_head)) begin
        tests_failed++; $display("FAIL b2b_%0d got ready %b valid %b payload %h want 1 1 %h",
                                 k, bus.enq_ready_o, bus.deq_valid_o, bus.deq_payload_o[31:0], next_head); end
      next_head++;
      tick();
      tests_run++; if (bus.count_o !== CNT_W'(4)) begin tests_failed++; $display("FAIL b2b_count_%0d got %0d want 4", k, bus.count_o); end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.inst_data_ok_i = 1'b1;
      #1;
      tests_run++; if (bus.deq_valid_o !== 1'b1 || bus.deq_payload_o !== PAYLOAD_W'(next_head)) begin
        tests_failed++; $display("FAIL b2b_drain_%0d got valid %b payload %h want 1 %h", i, bus.deq_valid_o, bus.deq_payload_o[31:0], next_head); end
      next_head++;
      tick();
      idle();
    end
    tests_run++; if (bus.empty_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty got %b want 1", bus.empty_o); end
  endtask

  task automatic test_cancel();
    for (int i = 1; i <= 3; i++) push_one(PAYLOAD_W'(8'h10 + i));
    bus.enq_valid_i   = 1'b1;
    bus.enq_payload_i = PAYLOAD_W'(9);
    bus.cancel_i      = 3'b010;
    tick();
    idle();
    tests_run++; if (bus.count_o !== CNT_W'(4)) begin tests_failed++; $display("FAIL cancel_count got %0d want 4", bus.count_o); end
    for (int i = 0; i < 4; i++) begin
      bus.inst_data_ok_i = 1'b1;
      #1;
      tests_run++; if (bus.deq_valid_o !== 1'b0) begin tests_failed++; $display("FAIL cancel_pop_%0d got valid %b want 0", i, bus.deq_valid_o); end
      tick();
      idle();
    end
    tests_run++; if (bus.empty_o !== 1'b1) begin tests_failed++; $display("FAIL cancel_drained got %b want 1", bus.empty_o); end
    push_one(PAYLOAD_W'(10));
    // Pop coincides with a new cancel: popped entry keeps its pre-edge state.
    bus.inst_data_ok_i = 1'b1;
    bus.cancel_i       = 3'b001;
    #1;
    tests_run++; if (bus.deq_valid_o !== 1'b1 || bus.deq_payload_o !== PAYLOAD_W'(10)) begin
      tests_failed++; $display("FAIL cancel_after got valid %b payload %h want 1 a", bus.deq_valid_o, bus.deq_payload_o[31:0]); end
    tick();
    idle();
  endtask

  task automatic test_exc_merge();
    idle();
    bus.enq_valid_i     = 1'b1;
    bus.enq_payload_i   = PAYLOAD_W'(8'h20);
    bus.enq_has_exc_i   = 1'b1;
    bus.enq_exc_code_i  = 5'h04;
    bus.mmu_has_exc_i   = 1'b1;
    bus.mmu_exc_code_i  = 5'h02;
    bus.mmu_is_refill_i = 1'b1;
    tick();
    bus.enq_payload_i   = PAYLOAD_W'(8'h21);
    bus.enq_has_exc_i   = 1'b0;
    tick();
    idle();
    bus.inst_data_ok_i = 1'b1;
    #1;
    tests_run++; if (bus.deq_has_exc_o !== 1'b1 || bus.deq_exc_code_o !== 5'h04 || bus.deq_is_refill_o !== 1'b0) begin
      tests_failed++; $display("FAIL exc_upstream got exc %b code %h refill %b want 1 04 0", bus.deq_has_exc_o, bus.deq_exc_code_o, bus.deq_is_refill_o); end
    tick();
    #1;
    tests_run++; if (bus.deq_has_exc_o !== 1'b1 || bus.deq_exc_code_o !== 5'h02 || bus.deq_is_refill_o !== 1'b1) begin
      tests_failed++; $display("FAIL exc_mmu got exc %b code %h refill %b want 1 02 1", bus.deq_has_exc_o, bus.deq_exc_code_o, bus.deq_is_refill_o); end
    tick();
    idle();
  endtask

  task automatic test_spurious();
    bus.inst_data_ok_i = 1'b1;
    #1;
    tests_run++; if (bus.deq_valid_o !== 1'b0) begin tests_failed++; $display("FAIL spur_valid got %b want 0", bus.deq_valid_o); end
    tick();
    idle();
    tests_run++; if (bus.spurious_ok_o !== 1'b1) begin tests_failed++; $display("FAIL spur_pulse got %b want 1", bus.spurious_ok_o); end
    tests_run++; if (bus.count_o !== CNT_W'(0)) begin tests_failed++; $display("FAIL spur_count got %0d want 0", bus.count_o); end
    tick();
    tests_run++; if (bus.spurious_ok_o !== 1'b0) begin tests_failed++; $display("FAIL spur_one_cycle got %b want 0", bus.spurious_ok_o); end
  endtask

  task automatic test_reset_mid();
    push_one(PAYLOAD_W'(8'h31));
    push_one(PAYLOAD_W'(8'h32));
    bus.enq_valid_i    = 1'b1;
    bus.enq_payload_i  = PAYLOAD_W'(8'h33);
    bus.inst_data_ok_i = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    tests_run++; if (bus.count_o !== CNT_W'(0) || bus.empty_o !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_state got count %0d empty %b want 0 1", bus.count_o, bus.empty_o); end
    tests_run++; if (bus.spurious_ok_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_spur0 got %b want 0", bus.spurious_ok_o); end
    bus.inst_data_ok_i = 1'b1;
    #1;
    tests_run++; if (bus.deq_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid got %b want 0", bus.deq_valid_o); end
    tick();
    idle();
    tests_run++; if (bus.spurious_ok_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_spur got %b want 1", bus.spurious_ok_o); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_cancel();
    test_exc_merge();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
